// File: rtl/apb_periph_hub.sv
// APB fan-out from one upstream port to NUM_SLAVES downstream slaves, with a control window
// (clock-gate enables, error log). Optional hung-transfer abort: define APB_PERIPH_HUB_TIMEOUT_EN.
module apb_periph_hub #(
   parameter int                    NUM_SLAVES     = 8,
   parameter int                    SLV_ADDR_WIDTH = 12,
   parameter int                    TIMEOUT_CYCLES = 256,
   parameter logic [NUM_SLAVES-1:0] CG_RESET       = '1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [31:0]                  paddr_i,
   input  logic                         psel_i,
   input  logic                         penable_i,
   input  logic                         pwrite_i,
   input  logic [31:0]                  pwdata_i,
   output logic [31:0]                  prdata_o,
   output logic                         pready_o,
   output logic                         pslverr_o,
   output logic [SLV_ADDR_WIDTH-1:0]    p_paddr_o,
   output logic [31:0]                  p_pwdata_o,
   output logic                         p_pwrite_o,
   output logic                         p_penable_o,
   output logic [NUM_SLAVES-1:0]        p_psel_o,
   input  logic [NUM_SLAVES*32-1:0]     p_prdata_i,
   input  logic [NUM_SLAVES-1:0]        p_pready_i,
   input  logic [NUM_SLAVES-1:0]        p_pslverr_i,
   output logic [NUM_SLAVES-1:0]        cg_en_o,
   output logic                         err_irq_o
);
   localparam int IDX_W = $clog2(NUM_SLAVES + 1);
   localparam int PAD   = 1 << IDX_W;

`ifdef APB_PERIPH_HUB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACCESS} state_t;
`endif

   state_t                  state_reg, state_next;
   logic [NUM_SLAVES-1:0]   cg_en_reg;
   logic                    err_valid_reg;
   logic [1:0]              err_cause_reg;
   logic [4:0]              err_idx_reg;
   logic [31:0]             err_addr_reg;
   logic                    err_irq_reg;

   logic [IDX_W-1:0]        idx;
   logic                    active, in_access, in_abort;
   logic                    is_ext, is_ctrl, unmapped, gated, route_ok;
   logic                    err_now, ctrl_wr, err_clr;
   logic [1:0]              cause_now;
   logic [31:0]             ctrl_rdata;
   logic [PAD-1:0]          cg_pad, rdy_pad, serr_pad;
   logic [31:0]             rdata_pad [PAD];

   assign idx       = paddr_i[SLV_ADDR_WIDTH+IDX_W-1:SLV_ADDR_WIDTH];
   assign active    = psel_i & ~rst_i;
   assign in_access = active & (state_reg == ACCESS);
   assign is_ext    = 32'(idx) < NUM_SLAVES;
   assign is_ctrl   = 32'(idx) == NUM_SLAVES;
   assign unmapped  = ~is_ext & ~is_ctrl;
   assign gated     = is_ext & ~cg_pad[idx];
   assign route_ok  = is_ext & cg_pad[idx] & ~in_abort;

`ifdef APB_PERIPH_HUB_TIMEOUT_EN
   logic [CNT_W-1:0] to_cnt_reg;
   assign in_abort = ~rst_i & (state_reg == ABORT);
`else
   assign in_abort = 1'b0;
`endif

   // Downstream vectors are padded to the full index range so out-of-map indices read as zero.
   for (genvar gi = 0; gi < PAD; gi++) begin : g_pad
      if (gi < NUM_SLAVES) begin : g_slv
         assign cg_pad[gi]    = cg_en_reg[gi];
         assign rdy_pad[gi]   = p_pready_i[gi];
         assign serr_pad[gi]  = p_pslverr_i[gi];
         assign rdata_pad[gi] = p_prdata_i[gi*32 +: 32];
         assign p_psel_o[gi]  = active & route_ok & (idx == IDX_W'(gi));
      end else begin : g_none
         assign cg_pad[gi]    = 1'b0;
         assign rdy_pad[gi]   = 1'b0;
         assign serr_pad[gi]  = 1'b0;
         assign rdata_pad[gi] = '0;
      end
   end

   assign p_paddr_o   = paddr_i[SLV_ADDR_WIDTH-1:0];
   assign p_pwdata_o  = pwdata_i;
   assign p_pwrite_o  = pwrite_i;
   assign p_penable_o = penable_i;
   assign cg_en_o     = cg_en_reg;
   assign err_irq_o   = err_irq_reg;

   always_comb begin
      ctrl_rdata = '0;
      case (paddr_i[3:2])
         2'd0:    ctrl_rdata = 32'(cg_en_reg);
         2'd1:    ctrl_rdata = {err_valid_reg, err_cause_reg, 24'd0, err_idx_reg};
         2'd2:    ctrl_rdata = err_addr_reg;
         default: ctrl_rdata = '0;
      endcase
   end

   always_comb begin
      pready_o  = 1'b0;
      pslverr_o = 1'b0;
      prdata_o  = '0;
      err_now   = 1'b0;
      cause_now = 2'b00;
      if (in_abort) begin
         pready_o  = 1'b1;
         pslverr_o = 1'b1;
         err_now   = 1'b1;
         cause_now = 2'b10;
      end else if (in_access) begin
         if (is_ctrl) begin
            pready_o = 1'b1;
            prdata_o = ctrl_rdata;
         end else if (unmapped || gated) begin
            pready_o  = 1'b1;
            pslverr_o = 1'b1;
            err_now   = 1'b1;
            cause_now = unmapped ? 2'b01 : 2'b11;
         end else begin
            pready_o  = rdy_pad[idx];
            pslverr_o = rdy_pad[idx] & serr_pad[idx];
            prdata_o  = rdata_pad[idx];
         end
      end
   end

   assign ctrl_wr = in_access & is_ctrl & pwrite_i;
   assign err_clr = ctrl_wr & (paddr_i[3:2] == 2'd3);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:   if (active && !penable_i) state_next = ACCESS;
         ACCESS: begin
            if (!active || pready_o) state_next = IDLE;
`ifdef APB_PERIPH_HUB_TIMEOUT_EN
            else if (to_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) state_next = ABORT;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         cg_en_reg     <= CG_RESET;
         err_valid_reg <= 1'b0;
         err_cause_reg <= '0;
         err_idx_reg   <= '0;
         err_addr_reg  <= '0;
         err_irq_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         err_irq_reg <= err_now;
         if (ctrl_wr && paddr_i[3:2] == 2'd0) cg_en_reg <= pwdata_i[NUM_SLAVES-1:0];
         // A clear in the same cycle as a new error still lets the new error in.
         if (err_now && (!err_valid_reg || err_clr)) begin
            err_cause_reg <= cause_now;
            err_idx_reg   <= 5'(idx);
            err_addr_reg  <= paddr_i;
         end
         if (err_now)      err_valid_reg <= 1'b1;
         else if (err_clr) err_valid_reg <= 1'b0;
      end
   end

`ifdef APB_PERIPH_HUB_TIMEOUT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                      to_cnt_reg <= '0;
      else if (state_reg == IDLE && state_next == ACCESS) to_cnt_reg <= '0;
      else if (state_reg == ACCESS && !pready_o)      to_cnt_reg <= to_cnt_reg + 1'b1;
   end
`endif

endmodule

// File: tb/tb_apb_periph_hub.sv
// Directed bench for apb_periph_hub: behavioural slaves, expected responses queued per transfer.
module tb_apb_periph_hub;
   localparam int NS = 8;
`ifdef APB_PERIPH_HUB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 256;
`endif

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [31:0]       paddr_i = '0;
   logic              psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
   logic [31:0]       pwdata_i = '0;
   logic [31:0]       prdata_o;
   logic              pready_o, pslverr_o;
   logic [11:0]       p_paddr_o;
   logic [31:0]       p_pwdata_o;
   logic              p_pwrite_o, p_penable_o;
   logic [NS-1:0]     p_psel_o;
   logic [NS*32-1:0]  p_prdata_i;
   logic [NS-1:0]     p_pready_i, p_pslverr_i;
   logic [NS-1:0]     cg_en_o;
   logic              err_irq_o;

   apb_periph_hub #(.NUM_SLAVES(NS), .SLV_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .paddr_i(paddr_i), .psel_i(psel_i), .penable_i(penable_i),
      .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o), .pready_o(pready_o),
      .pslverr_o(pslverr_o), .p_paddr_o(p_paddr_o), .p_pwdata_o(p_pwdata_o),
      .p_pwrite_o(p_pwrite_o), .p_penable_o(p_penable_o), .p_psel_o(p_psel_o),
      .p_prdata_i(p_prdata_i), .p_pready_i(p_pready_i), .p_pslverr_i(p_pslverr_i),
      .cg_en_o(cg_en_o), .err_irq_o(err_irq_o));

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      bit          chk_rd;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          irq_cnt = 0;
   int          irq0;
   logic [31:0] last_rd;
   int          wait_cfg [NS];
   logic [31:0] rdata_cfg [NS];
   bit          err_cfg [NS];
   int          wcnt [NS];

   // Slave s raises pready after wait_cfg[s] wait cycles in its access phase.
   always @(posedge clk_i) begin
      for (int s = 0; s < NS; s++) begin
         if (p_psel_o[s] && p_penable_o && !p_pready_i[s]) wcnt[s] <= wcnt[s] + 1;
         else wcnt[s] <= 0;
      end
      if (err_irq_o) irq_cnt <= irq_cnt + 1;
   end

   always_comb begin
      p_pready_i  = '0;
      p_pslverr_i = '0;
      p_prdata_i  = '0;
      for (int s = 0; s < NS; s++) begin
         p_pready_i[s]          = p_psel_o[s] && p_penable_o && (wcnt[s] >= wait_cfg[s]);
         p_pslverr_i[s]         = p_pready_i[s] && err_cfg[s];
         p_prdata_i[s*32 +: 32] = rdata_cfg[s];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input bit chk_rd,
                       input logic [7:0] exp_sel, input int exp_lat);
      exp_t        e;
      logic [7:0]  sel;
      logic        er;
      int          lat;
      e.rdata = exp_rd; e.err = exp_err; e.chk_rd = chk_rd;
      exp_q.push_back(e);
      @(negedge clk_i);
      paddr_i = addr; pwrite_i = wr; pwdata_i = wdata; psel_i = 1'b1; penable_i = 1'b0;
      @(negedge clk_i);
      penable_i = 1'b1;
      lat = 0;
      sel = '0;
      for (int i = 0; i < 64; i++) begin
         #1;
         sel = p_psel_o;
         if (pready_o === 1'b1) break;
         @(negedge clk_i);
         lat++;
      end
      last_rd = prdata_o;
      er = pslverr_o;
      chk("pready_bound", 32'(pready_o), 32'd1);
      e = exp_q.pop_front();
      if (e.chk_rd) chk("prdata", last_rd, e.rdata);
      chk("pslverr", 32'(er), 32'(e.err));
      chk("psel", 32'(sel), 32'(exp_sel));
      chk("latency", lat, exp_lat);
      $display("xfer addr=%h wr=%0d rdata=%h slverr=%0d psel=%h lat=%0d", addr, wr, last_rd, er, sel, lat);
      @(posedge clk_i);
      #1;
      psel_i = 1'b0; penable_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int s = 0; s < NS; s++) begin
         rdata_cfg[s] = 32'h1000_0000 + 32'(s * 32'h111);
         err_cfg[s]   = 1'b0;
         wcnt[s]      = 0;
      end
      wait_cfg = '{0, 1, 3, 5, 1, 1000, 0, 2};
      rdata_cfg[2] = 32'hCAFE_0001;
      err_cfg[6]   = 1'b1;

      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("rst_psel", 32'(p_psel_o), 32'h0);
      chk("rst_cg", 32'(cg_en_o), 32'hFF);
      chk("rst_pready", 32'(pready_o), 32'h0);
      chk("rst_prdata", prdata_o, 32'h0);
      chk("rst_irq", 32'(err_irq_o), 32'h0);
      xfer(32'h8004, 0, 0, 32'h0, 0, 1, 8'h00, 0);

      // routed reads and writes
      xfer(32'h2004, 0, 0, 32'hCAFE_0001, 0, 1, 8'h04, 3);
      xfer(32'h0010, 0, 0, 32'h1000_0000, 0, 1, 8'h01, 0);
      xfer(32'h4000, 1, 32'h55, 32'h0, 0, 0, 8'h10, 1);
      xfer(32'h6000, 0, 0, 32'h1000_0666, 1, 1, 8'h40, 0);

      // gate slave 2, then hit it
      xfer(32'h8000, 1, 32'hFB, 32'h0, 0, 0, 8'h00, 0);
      xfer(32'h8000, 0, 0, 32'hFB, 0, 1, 8'h00, 0);
      chk("cg_after_wr", 32'(cg_en_o), 32'hFB);
      irq0 = irq_cnt;
      xfer(32'h2000, 0, 0, 32'h0, 1, 1, 8'h00, 0);
      repeat (2) @(negedge clk_i);
      chk("irq_gated", irq_cnt - irq0, 1);
      xfer(32'h8004, 0, 0, 32'hE000_0002, 0, 1, 8'h00, 0);
      xfer(32'h8008, 0, 0, 32'h0000_2000, 0, 1, 8'h00, 0);
      xfer(32'h800C, 1, 0, 32'h0, 0, 0, 8'h00, 0);
      xfer(32'h8004, 0, 0, 32'h0, 0, 0, 8'h00, 0);
      chk("clr_valid", 32'(last_rd[31]), 32'h0);

      // unmapped index 9
      xfer(32'h9010, 0, 0, 32'h0, 1, 1, 8'h00, 0);
      xfer(32'h8004, 0, 0, 32'hA000_0009, 0, 1, 8'h00, 0);
      xfer(32'h8008, 0, 0, 32'h0000_9010, 0, 1, 8'h00, 0);

      // back-to-back errors: first one is kept
      xfer(32'h800C, 1, 0, 32'h0, 0, 0, 8'h00, 0);
      irq0 = irq_cnt;
      xfer(32'hA000, 0, 0, 32'h0, 1, 1, 8'h00, 0);
      xfer(32'h2008, 0, 0, 32'h0, 1, 1, 8'h00, 0);
      repeat (2) @(negedge clk_i);
      chk("irq_b2b", irq_cnt - irq0, 2);
      xfer(32'h8004, 0, 0, 32'hA000_000A, 0, 1, 8'h00, 0);
      xfer(32'h8008, 0, 0, 32'h0000_A000, 0, 1, 8'h00, 0);
      xfer(32'h800C, 1, 0, 32'h0, 0, 0, 8'h00, 0);
      xfer(32'h8004, 0, 0, 32'h0, 0, 0, 8'h00, 0);
      chk("clr_valid2", 32'(last_rd[31]), 32'h0);
      xfer(32'h800C, 0, 0, 32'h0, 0, 1, 8'h00, 0);

      // ungate and re-read slave 2; then reset mid-transfer on slave 3
      xfer(32'h8000, 1, 32'h7F, 32'h0, 0, 0, 8'h00, 0);
      xfer(32'h2000, 0, 0, 32'hCAFE_0001, 0, 1, 8'h04, 3);
      chk("cg_7f", 32'(cg_en_o), 32'h7F);
      @(negedge clk_i);
      paddr_i = 32'h3000; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
      @(negedge clk_i);
      penable_i = 1'b1;
      #1;
      chk("mid_psel_pre", 32'(p_psel_o), 32'h08);
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_psel", 32'(p_psel_o), 32'h0);
      chk("mid_rst_cg", 32'(cg_en_o), 32'hFF);
      chk("mid_rst_pready", 32'(pready_o), 32'h0);
      @(negedge clk_i);
      psel_i = 1'b0; penable_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      xfer(32'h3004, 0, 0, 32'h1000_0333, 0, 1, 8'h08, 5);
      xfer(32'h8004, 0, 0, 32'h0, 0, 1, 8'h00, 0);

`ifdef APB_PERIPH_HUB_TIMEOUT_EN
      irq0 = irq_cnt;
      xfer(32'h5000, 0, 0, 32'h0, 1, 1, 8'h00, 16);
      repeat (2) @(negedge clk_i);
      chk("irq_timeout", irq_cnt - irq0, 1);
      xfer(32'h8004, 0, 0, 32'hC000_0005, 0, 1, 8'h00, 0);
      xfer(32'h0000, 0, 0, 32'h1000_0000, 0, 1, 8'h01, 0);
`endif

      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
